rf_write_arbiter: RTL and testbench

//  Write-side front end of the 32x32 MIPS register file. Merges two result producers onto the

---
 rtl/rf_wb_pkg.sv | 18 +
 rtl/rf_wb_queue.sv | 86 ++++++++
 rtl/rf_write_arbiter.sv | 128 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared types and widths for the register-file write-back front end.
`default_nettype none

package rf_wb_pkg;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/rf_wb_queue.sv
// Late-path write queue: ordered oldest-first, killed entries squeezed out each cycle.
`default_nettype none

module rf_wb_queue
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  wb_entry_t     push_entry_i,
  input  logic          pop_i,
  input  logic          kill_i,
  input  logic [AW-1:0] kill_addr_i,
  output wb_entry_t     head_o,
  output logic [CW-1:0] count_o,
  input  logic [AW-1:0] l1_addr_i,
  output logic          l1_hit_o,
  output logic [DW-1:0] l1_data_o,
  input  logic [AW-1:0] l2_addr_i,
  output logic          l2_hit_o,
  output logic [DW-1:0] l2_data_o
);

  wb_entry_t     ent_q [DEPTH];
  wb_entry_t     ent_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] fill;

  // Survivors are repacked from slot 0 so every stored entry is live and the
  // live count is also the occupancy; dead entries never block new pushes.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
    fill = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && !(pop_i && (i == 0)) &&
          !(kill_i && (ent_q[i].addr == kill_addr_i))) begin
        ent_d[fill[IW-1:0]] = ent_q[i];
        fill = fill + CW'(1);
      end
    end
    if (push_i && (fill < CW'(DEPTH))) begin
      ent_d[fill[IW-1:0]]       = push_entry_i;
      ent_d[fill[IW-1:0]].valid = 1'b1;
      fill = fill + CW'(1);
    end
    cnt_d = fill;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = ent_q[0];
  assign count_o = cnt_q;

  // Ascending scan so the youngest matching entry is the one that sticks.
  always_comb begin
    l1_hit_o  = 1'b0;
    l1_data_o = '0;
    l2_hit_o  = 1'b0;
    l2_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && (ent_q[i].addr == l1_addr_i)) begin
        l1_hit_o  = 1'b1;
        l1_data_o = ent_q[i].data;
      end
      if (ent_q[i].valid && (ent_q[i].addr == l2_addr_i)) begin
        l2_hit_o  = 1'b1;
        l2_data_o = ent_q[i].data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rf_write_arbiter.sv
// Merges the ALU and late result paths onto the register file's single write port,
// with stale-write kill and decode forwarding.
`default_nettype none

module rf_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          WE3,
  output logic [AW-1:0] A3,
  output logic [DW-1:0] WD3,
  output logic [CW-1:0] q_count,
  input  logic [AW-1:0] f1_addr,
  output logic          f1_hit,
  output logic [DW-1:0] f1_data,
  input  logic [AW-1:0] f2_addr,
  output logic          f2_hit,
  output logic [DW-1:0] f2_data
);

  import rf_wb_pkg::wb_entry_t;
  import rf_wb_pkg::REG_ZERO;

  logic          we_q, we_d;
  logic [AW-1:0] a3_q, a3_d;
  logic [DW-1:0] wd3_q, wd3_d;

  logic          a_wr;
  logic          b_push;
  logic          pop;
  wb_entry_t     head;
  wb_entry_t     push_entry;
  logic          qh1, qh2;
  logic [DW-1:0] qd1, qd2;

  assign b_ready    = (q_count < CW'(DEPTH));
  assign a_wr       = a_valid && (a_addr != REG_ZERO);
  assign b_push     = b_valid && b_ready && (b_addr != REG_ZERO);
  assign pop        = !a_wr && head.valid;
  assign push_entry = '{valid: 1'b1, addr: b_addr, data: b_data};

  rf_wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk          (CLK),
    .rst_n        (rst),
    .push_i       (b_push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .kill_i       (a_wr),
    .kill_addr_i  (a_addr),
    .head_o       (head),
    .count_o      (q_count),
    .l1_addr_i    (f1_addr),
    .l1_hit_o     (qh1),
    .l1_data_o    (qd1),
    .l2_addr_i    (f2_addr),
    .l2_hit_o     (qh2),
    .l2_data_o    (qd2)
  );

  always_comb begin
    we_d  = 1'b0;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (a_wr) begin
      we_d  = 1'b1;
      a3_d  = a_addr;
      wd3_d = a_data;
    end else if (head.valid) begin
      we_d  = 1'b1;
      a3_d  = head.addr;
      wd3_d = head.data;
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      we_q  <= 1'b0;
      a3_q  <= '0;
      wd3_q <= '0;
    end else begin
      we_q  <= we_d;
      a3_q  <= a3_d;
      wd3_q <= wd3_d;
    end
  end

  assign WE3 = we_q;
  assign A3  = a3_q;
  assign WD3 = wd3_q;

  // Queued values are younger than the one sitting in the output stage.
  always_comb begin
    f1_hit  = 1'b0;
    f1_data = wd3_q;
    f2_hit  = 1'b0;
    f2_data = wd3_q;
    if (f1_addr != REG_ZERO) begin
      if (qh1) begin
        f1_hit  = 1'b1;
        f1_data = qd1;
      end else if (we_q && (a3_q == f1_addr)) begin
        f1_hit  = 1'b1;
      end
    end
    if (f2_addr != REG_ZERO) begin
      if (qh2) begin
        f2_hit  = 1'b1;
        f2_data = qd2;
      end else if (we_q && (a3_q == f2_addr)) begin
        f2_hit  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench: a queue-level reference model predicts every register-file write.
`timescale 1ns/1ps
`default_nettype none

module tb_rf_write_arbiter;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, b_ready;
  logic [4:0]  a_addr, b_addr, A3, f1_addr, f2_addr;
  logic [31:0] a_data, b_data, WD3, f1_data, f2_data;
  logic        WE3, f1_hit, f2_hit;
  logic [2:0]  q_count;

  rf_write_arbiter #(.DEPTH(DEPTH), .DW(32), .AW(5)) dut (
    .CLK(CLK), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .WE3(WE3), .A3(A3), .WD3(WD3), .q_count(q_count),
    .f1_addr(f1_addr), .f1_hit(f1_hit), .f1_data(f1_data),
    .f2_addr(f2_addr), .f2_hit(f2_hit), .f2_data(f2_data)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [4:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [4:0] addr; logic [31:0] data; int cyc; } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          done = 0;
  wr_t         pend[$];
  exp_t        exp_q[$];
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] prog   [32];
  logic [31:0] dut_rf [32];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void fwd(input logic [4:0] a, output bit hit, output logic [31:0] d);
    hit = 0;
    d = '0;
    if (a == 5'd0) return;
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].addr == a) begin
        hit = 1;
        d = pend[i].data;
        return;
      end
    end
    if (m_we && m_addr == a) begin
      hit = 1;
      d = m_data;
    end
  endfunction

  // One cycle: drive at negedge, check registered-state outputs, advance model.
  task automatic step(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                      input bit bv, input logic [4:0] ba, input logic [31:0] bd,
                      input logic [4:0] fa1, input logic [4:0] fa2);
    bit          h;
    logic [31:0] d;
    bit          b_acc;
    wr_t         w;
    @(negedge CLK);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    f1_addr = fa1; f2_addr = fa2;
    #1;
    chk("q_count", 32'(q_count), 32'(pend.size()));
    chk("b_ready", 32'(b_ready), 32'(pend.size() < DEPTH));
    fwd(fa1, h, d);
    chk("f1_hit", 32'(f1_hit), 32'(h));
    if (h) chk("f1_data", f1_data, d);
    fwd(fa2, h, d);
    chk("f2_hit", 32'(f2_hit), 32'(h));
    if (h) chk("f2_data", f2_data, d);

    b_acc = bv && (pend.size() < DEPTH);
    if (av && aa != 5'd0) begin
      for (int i = pend.size() - 1; i >= 0; i--)
        if (pend[i].addr == aa) pend.delete(i);
      prog[aa] = ad;
      m_we = 1; m_addr = aa; m_data = ad;
      exp_q.push_back('{aa, ad, cyc + 1});
    end else if (pend.size() > 0) begin
      w = pend.pop_front();
      m_we = 1; m_addr = w.addr; m_data = w.data;
      exp_q.push_back('{w.addr, w.data, cyc + 1});
    end else begin
      m_we = 0;
    end
    if (b_acc && ba != 5'd0) begin
      pend.push_back('{ba, bd});
      prog[ba] = bd;
    end
  endtask

  task automatic idle(input int n, input logic [4:0] fa1, input logic [4:0] fa2);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, fa1, fa2);
  endtask

  task automatic clear_model();
    pend.delete();
    exp_q.delete();
    m_we = 0; m_addr = '0; m_data = '0;
    for (int r = 0; r < 32; r++) begin
      prog[r] = '0;
      dut_rf[r] = '0;
    end
  endtask

  // Monitor: every observed write must be the next expected one, in its cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (rst && !done) begin
        if (WE3) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: got A3=%0d WD3=%0h expected no write (cycle %0d)", A3, WD3, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("write_cycle", 32'(cyc), 32'(e.cyc));
            chk("A3", 32'(A3), 32'(e.addr));
            chk("WD3", WD3, e.data);
          end
          dut_rf[A3] = WD3;
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          e = exp_q.pop_front();
          checks++; errors++;
          $display("FAIL missing_write: got WE3=0 expected A3=%0d WD3=%0h (cycle %0d)", e.addr, e.data, cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0;
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    f1_addr = 5'd5; f2_addr = 5'd0;
    clear_model();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_WE3", 32'(WE3), 0);
    chk("rst_A3", 32'(A3), 0);
    chk("rst_WD3", WD3, 0);
    chk("rst_q_count", 32'(q_count), 0);
    chk("rst_f1_hit", 32'(f1_hit), 0);
    @(negedge CLK);
    rst = 1;

    // ALU write, visible on the port and forwarded one cycle later
    step(1, 5, 32'hAAAA, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 5, 0);

    // fill the queue behind continuous ALU traffic, then drain
    for (int i = 0; i < 4; i++)
      step(1, 5'(10 + i), 32'h500 + i, 1, 5'(1 + i), 32'h100 + i, 5'(1 + i), 5'(10 + i));
    step(1, 14, 32'h514, 1, 5, 32'hDEAD, 1, 4);
    idle(6, 4, 3);

    // kill of a stale queued write; same-cycle ALU and late write to one register
    step(0, 0, 0, 1, 7, 32'h11, 7, 0);
    step(1, 7, 32'h22, 0, 0, 0, 7, 0);
    step(0, 0, 0, 0, 0, 0, 7, 0);
    step(1, 8, 32'h33, 1, 8, 32'h44, 8, 0);
    idle(3, 8, 7);

    // $zero on both paths
    step(1, 0, 32'h55, 1, 0, 32'h66, 0, 0);
    idle(2, 0, 0);

    // two queued writes to the same register: youngest forwarded
    step(0, 0, 0, 1, 9, 32'h1, 0, 9);
    step(0, 0, 0, 1, 9, 32'h2, 0, 9);
    step(0, 0, 0, 0, 0, 0, 0, 9);
    idle(3, 9, 9);

    // asynchronous reset with queued entries and an active write
    for (int i = 0; i < 3; i++)
      step(1, 5'(24 + i), 32'h700 + i, 1, 5'(20 + i), 32'h600 + i, 0, 0);
    step(1, 27, 32'h727, 0, 0, 0, 20, 24);
    chk("pre_rst_WE3", 32'(WE3), 1);
    rst = 0;
    #1;
    chk("arst_WE3", 32'(WE3), 0);
    chk("arst_A3", 32'(A3), 0);
    chk("arst_WD3", WD3, 0);
    chk("arst_q_count", 32'(q_count), 0);
    clear_model();
    a_valid = 0; b_valid = 0;
    @(posedge CLK);
    @(negedge CLK);
    rst = 1;

    // randomized traffic on a small register window to force collisions
    for (int n = 0; n < 2000; n++)
      step($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

    for (int n = 0; n < 20 && pend.size() > 0; n++) idle(1, 0, 0);
    idle(3, 0, 0);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    for (int r = 1; r < 32; r++) chk($sformatf("rf_r%0d", r), dut_rf[r], prog[r]);

    done = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
